// File: rtl/ram_stream_reader.sv
// Read initiator for one port of the feature-map RAM: issues sequential reads,
// absorbs the fixed RAM latency and delivers the words as a valid/ready stream.
module ram_stream_reader #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_re,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + READ_LATENCY + 2);
  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t                 state, state_next;
  logic [ADDR_WIDTH-1:0]  addr_cnt, addr_src;
  logic [ADDR_WIDTH:0]    issue_cnt, cnt_src;
  logic [READ_LATENCY:0]  vpipe, lpipe;
  logic [DATA_WIDTH:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [PW:0]            fifo_count;
  logic [CW-1:0]          inflight, used;
  logic                   issue, issue_last, push, pop, head_last, credit;

  // Stream handshake: a word transfers on every edge where m_valid and m_ready
  // are both high; while m_valid is high the head entry is held unchanged.
  assign m_valid   = (fifo_count != '0);
  assign pop       = m_valid && m_ready;
  assign head_last = fifo_mem[rd_ptr][DATA_WIDTH];
  assign m_data    = m_valid ? fifo_mem[rd_ptr][DATA_WIDTH-1:0] : '0;
  assign m_last    = m_valid && head_last;
  assign push      = vpipe[READ_LATENCY];
  assign ram_re    = vpipe[0];
  assign ram_we    = 1'b0;
  assign ram_din   = '0;

  always_comb begin
    inflight = '0;
    for (int i = 0; i <= READ_LATENCY; i++) inflight = inflight + CW'(vpipe[i]);
  end

  // A slot freed by this cycle's pop is reusable at once; without it the
  // default sizing would stall every other cycle.
  assign used   = CW'(fifo_count) + inflight - CW'(pop);
  assign credit = (used < CW'(FIFO_DEPTH));

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    addr_src   = addr_cnt;
    cnt_src    = issue_cnt;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        addr_src = base_addr;
        cnt_src  = length;
        if (start) begin
          if (length == '0) begin
            state_next = FIN;
          end else begin
            issue      = 1'b1;
            state_next = RUN;
          end
        end
      end
      RUN: begin
        busy = 1'b1;
        if (issue_cnt != '0 && credit) issue = 1'b1;
        if (issue_cnt == '0 || (issue && issue_cnt == CNT_ONE)) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (inflight == '0 && pop && head_last) state_next = FIN;
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    issue_last = issue && (cnt_src == CNT_ONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr  <= '0;
      addr_cnt  <= '0;
      issue_cnt <= '0;
      vpipe     <= '0;
      lpipe     <= '0;
    end else begin
      if (issue) begin
        ram_addr  <= addr_src;
        addr_cnt  <= addr_src + 1'b1;
        issue_cnt <= cnt_src - 1'b1;
      end
      // vpipe[k] marks a read whose data reaches ram_q k cycles after ram_re
      if (READ_LATENCY > 0) begin
        vpipe <= {vpipe[READ_LATENCY-1:0], issue};
        lpipe <= {lpipe[READ_LATENCY-1:0], issue_last};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {lpipe[READ_LATENCY], ram_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && fifo_count == (PW+1)'(FIFO_DEPTH)));

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader: RAM model holding ram[i]=i, a table of
// full-throughput jobs plus stall, restart-while-busy and mid-job reset cases.
module tb_ram_stream_reader;

  localparam int DW = 16;
  localparam int AW = 8;

  // clock / reset
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy, done, ram_we, ram_re, m_valid, m_last;
  logic          m_ready = 1'b0;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, m_data;
  logic [DW-1:0] ram_q = '0;
  logic [DW-1:0] ram_s1 = '0;
  logic [DW-1:0] mem [256];

  always #5 clk = ~clk;

  // two registered stages: address sampled at an edge, q valid two cycles on
  always @(posedge clk) begin
    ram_s1 <= mem[ram_addr];
    ram_q  <= ram_s1;
  end

  ram_stream_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
    .ram_re(ram_re), .ram_q(ram_q), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last)
  );

  // scoreboard state
  int errors = 0;
  int checks = 0;
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] addr_q[$];
  int re_count, re_before, last_cnt, last_idx, done_count, done_cyc;
  int first_valid, stall_bad, busy_bad;

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic [DW-1:0] first;
    logic [DW-1:0] last;
    int            done_cyc;
    int            first_valid;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // driver + monitor: start is sampled at edge 0, cycle c ends at edge c
  task automatic run_job(input logic [AW-1:0] b, input logic [AW:0] n,
                         input int ready_from, input int restart_cyc, input int max_cyc);
    logic          prev_stalled;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    got_q.delete();
    addr_q.delete();
    re_count = 0; re_before = 0; last_cnt = 0; last_idx = -1;
    done_count = 0; done_cyc = 0; first_valid = 0; stall_bad = 0; busy_bad = 0;
    prev_stalled = 1'b0; prev_data = '0; prev_last = 1'b0;
    base_addr = b;
    length    = n;
    start     = 1'b1;
    m_ready   = (ready_from <= 0);
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      m_ready = (c >= ready_from);
      start   = (c == restart_cyc);
      if (c == restart_cyc) begin
        base_addr = 8'h40;
        length    = 9'd3;
      end
      @(negedge clk);
      if (ram_re) begin
        addr_q.push_back(ram_addr);
        re_count++;
        if (c < ready_from) re_before++;
      end
      if (prev_stalled && (!m_valid || m_data !== prev_data || m_last !== prev_last)) stall_bad++;
      prev_stalled = m_valid && !m_ready;
      prev_data    = m_data;
      prev_last    = m_last;
      if (m_valid && first_valid == 0) first_valid = c;
      if (m_valid && m_ready) begin
        if (m_last) begin
          last_cnt++;
          last_idx = got_q.size();
        end
        got_q.push_back(m_data);
      end
      if (busy !== ((n != '0) && !done && done_cyc == 0)) busy_bad++;
      if (done) begin
        done_count++;
        if (done_cyc == 0) done_cyc = c;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done_cyc != 0 && c > done_cyc) break;
    end
    m_ready = 1'b0;
  endtask

  task automatic check_job(input string tag, input logic [AW-1:0] b, input logic [AW:0] n,
                           input int exp_done, input int exp_fv);
    int bad_d, bad_a;
    exp_q.delete();
    for (int i = 0; i < int'(n); i++) exp_q.push_back(DW'((int'(b) + i) % 256));
    bad_d = 0;
    bad_a = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) bad_d++;
    for (int i = 0; i < addr_q.size() && i < exp_q.size(); i++)
      if (DW'(addr_q[i]) !== exp_q[i]) bad_a++;
    check({tag, "_word_count"}, got_q.size(), int'(n));
    check({tag, "_word_data_bad"}, bad_d, 0);
    check({tag, "_re_count"}, re_count, int'(n));
    check({tag, "_addr_bad"}, bad_a, 0);
    check({tag, "_last_count"}, last_cnt, (n != '0) ? 1 : 0);
    if (n != '0) check({tag, "_last_index"}, last_idx, int'(n) - 1);
    check({tag, "_done_count"}, done_count, 1);
    check({tag, "_done_cycle"}, done_cyc, exp_done);
    check({tag, "_first_valid_cycle"}, first_valid, exp_fv);
    check({tag, "_stall_unstable"}, stall_bad, 0);
    check({tag, "_busy_bad"}, busy_bad, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_ram_addr"}, int'(ram_addr), 0);
    check({tag, "_ram_re"}, int'(ram_re), 0);
    check({tag, "_m_valid"}, int'(m_valid), 0);
    check({tag, "_m_last"}, int'(m_last), 0);
    check({tag, "_m_data"}, int'(m_data), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = DW'(i);
    //          base   len     first    last     done first_valid
    vecs[0] = '{8'h10, 9'd4,   16'h10,  16'h13,  8,   4};
    vecs[1] = '{8'hFE, 9'd4,   16'hFE,  16'h01,  8,   4};
    vecs[2] = '{8'h00, 9'd1,   16'h00,  16'h00,  5,   4};
    vecs[3] = '{8'h80, 9'd7,   16'h80,  16'h86,  11,  4};
    vecs[4] = '{8'h05, 9'd0,   16'h00,  16'h00,  1,   0};
    vecs[5] = '{8'h01, 9'd256, 16'h01,  16'h00,  260, 4};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    check("reset_ram_we", int'(ram_we), 0);
    check("reset_ram_din", int'(ram_din), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int r = 0; r < 6; r++) begin
      run_job(vecs[r].base, vecs[r].len, 0, -1, int'(vecs[r].len) + 40);
      check_job($sformatf("row%0d", r), vecs[r].base, vecs[r].len,
                vecs[r].done_cyc, vecs[r].first_valid);
      if (vecs[r].len != '0 && got_q.size() > 0) begin
        check($sformatf("row%0d_first_word", r), int'(got_q[0]), int'(vecs[r].first));
        check($sformatf("row%0d_last_word", r), int'(got_q[got_q.size()-1]), int'(vecs[r].last));
      end
    end

    // backpressure: ready low for cycles 0-20, FIFO fills with 4 words
    run_job(8'h00, 9'd16, 21, -1, 100);
    check_job("stall", 8'h00, 9'd16, 37, 4);
    check("stall_re_before_ready_le4", int'(re_before <= 4), 1);
    check("stall_re_before_ready_nonzero", int'(re_before > 0), 1);

    // second start while busy is ignored
    run_job(8'h20, 9'd8, 0, 3, 60);
    check_job("restart", 8'h20, 9'd8, 12, 4);

    // reset asserted in cycle 5 of a length-8 job
    base_addr = 8'h30;
    length    = 9'd8;
    start     = 1'b1;
    m_ready   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midreset_pre_m_valid", int'(m_valid), 1);
    check("midreset_pre_ram_re", int'(ram_re), 1);
    check("midreset_pre_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_job(8'h00, 9'd2, 0, -1, 50);
    check_job("after_reset", 8'h00, 9'd2, 6, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
